// File: rtl/md_sched_pkg.sv
// Shared opcode encodings, FSM states and latency defaults for the MD scheduler.
// Consumed by md_sched and md_sched_core.
package md_sched_pkg;

    typedef enum logic [3:0] {
        MD_MULT  = 4'd0,
        MD_MULTU = 4'd1,
        MD_DIV   = 4'd2,
        MD_DIVU  = 4'd3,
        MD_MTHI  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MFHI  = 4'd6,
        MD_MFLO  = 4'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W        = 8;

    // Multiply/divide opcodes occupy the first four encodings.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/md_sched_core.sv
// Combinational 64-bit multiply and 32-bit divide for the MD scheduler.
// Divide results: lo = quotient, hi = remainder, truncation toward zero.
module md_sched_core
    import md_sched_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_n,
    output logic [31:0] lo_n,
    output logic        div_zero
);

    logic        a_neg;
    logic        b_neg;
    logic        a_ext;
    logic        b_ext;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] prod;

    always_comb begin
        a_ext  = (op == MD_MULT) & a[31];
        b_ext  = (op == MD_MULT) & b[31];
        prod   = {{32{a_ext}}, a} * {{32{b_ext}}, b};

        // Signed divide runs on magnitudes; signs are reapplied afterwards.
        a_neg  = (op == MD_DIV) & a[31];
        b_neg  = (op == MD_DIV) & b[31];
        a_mag  = a_neg ? (~a + 32'd1) : a;
        b_mag  = b_neg ? (~b + 32'd1) : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quo    = a_mag / b_safe;
        rem    = a_mag % b_safe;

        div_zero = (b == 32'd0);
        hi_n     = 32'd0;
        lo_n     = 32'd0;

        case (op)
            MD_MULT, MD_MULTU: begin
                hi_n = prod[63:32];
                lo_n = prod[31:0];
            end
            MD_DIV, MD_DIVU: begin
                lo_n = (a_neg ^ b_neg) ? (~quo + 32'd1) : quo;
                hi_n = a_neg ? (~rem + 32'd1) : rem;
            end
            default: begin
                hi_n = 32'd0;
                lo_n = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide scheduler owning HI/LO for the E stage.
// Holds the issue/busy FSM, latency down-counter and the stall request.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [3:0]  E_mdop,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_is_md,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] E_mf_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [31:0]      res_hi_q, res_hi_n;
    logic [31:0]      res_lo_q, res_lo_n;
    logic             res_dz_q, res_dz_n;
    logic [31:0]      hi_q, hi_n;
    logic [31:0]      lo_q, lo_n;

    logic [31:0]      core_hi;
    logic [31:0]      core_lo;
    logic             core_dz;
    logic             start_md;

    md_sched_core u_core (
        .op       (E_mdop),
        .a        (E_rs),
        .b        (E_rt),
        .hi_n     (core_hi),
        .lo_n     (core_lo),
        .div_zero (core_dz)
    );

    assign start_md = E_start & is_muldiv(E_mdop);

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        res_hi_n = res_hi_q;
        res_lo_n = res_lo_q;
        res_dz_n = res_dz_q;
        hi_n     = hi_q;
        lo_n     = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start_md) begin
                    res_hi_n = core_hi;
                    res_lo_n = core_lo;
                    res_dz_n = core_dz & E_mdop[1];
                    cnt_n    = E_mdop[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                    state_n  = ST_BUSY;
                end else if (E_start && (E_mdop == MD_MTHI)) begin
                    hi_n = E_rs;
                end else if (E_start && (E_mdop == MD_MTLO)) begin
                    lo_n = E_rs;
                end
            end
            ST_BUSY: begin
                // A start while busy cannot happen under the stall protocol and is ignored.
                if (cnt_q == '0) begin
                    if (!res_dz_q) begin
                        hi_n = res_hi_q;
                        lo_n = res_lo_q;
                    end
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_dz_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            res_hi_q <= res_hi_n;
            res_lo_q <= res_lo_n;
            res_dz_q <= res_dz_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
        end
    end

    assign busy     = (state_q == ST_BUSY);
    assign md_stall = D_is_md & (busy | start_md);
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_comb begin
        E_mf_data = 32'd0;
        if (E_start && (E_mdop == MD_MFHI)) E_mf_data = hi_q;
        else if (E_start && (E_mdop == MD_MFLO)) E_mf_data = lo_q;
    end

    no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(E_start && busy));

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed scenarios then random issue,
// all compared against an arithmetic HI/LO/latency model.
module tb_md_sched;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        E_start;
    logic [3:0]  E_mdop;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_is_md;
    logic        busy;
    logic        md_stall;
    logic [31:0] E_mf_data;
    logic [31:0] hi;
    logic [31:0] lo;

    md_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_start   (E_start),
        .E_mdop    (E_mdop),
        .E_rs      (E_rs),
        .E_rt      (E_rt),
        .D_is_md   (D_is_md),
        .busy      (busy),
        .md_stall  (md_stall),
        .E_mf_data (E_mf_data),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        armed  = 1'b0;
    int          n_busy;
    int          n_stall;
    logic [31:0] last_mf;

    // Reference state: cycles of busy remaining, pending result, architectural HI/LO.
    int          m_rem = 0;
    logic [31:0] m_ph  = 32'd0;
    logic [31:0] m_pl  = 32'd0;
    logic        m_pdz = 1'b0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd0: begin sp = sa * sb; return {1'b0, sp[63:0]}; end
            4'd1: begin up = ua * ub; return {1'b0, up[63:0]}; end
            4'd2: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                sq = sa / sb;
                sr = sa % sb;
                return {1'b0, sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                uq = ua / ub;
                ur = ua % ub;
                return {1'b0, ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic cyc(input logic st, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic dmd, input logic rst);
        logic [64:0] r;
        logic [31:0] exp_mf;
        @(negedge clk);
        E_start = st;
        E_mdop  = op;
        E_rs    = rs;
        E_rt    = rt;
        D_is_md = dmd;
        reset   = rst;
        #1;
        if (armed) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
            chk("md_stall", {31'd0, md_stall}, {31'd0, dmd & ((m_rem > 0) | (st & (op < 4'd4)))});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            if (st) begin
                exp_mf = (op == 4'd6) ? m_hi : (op == 4'd7) ? m_lo : 32'd0;
                chk("mf_data", E_mf_data, exp_mf);
                last_mf = E_mf_data;
            end
            if (busy) n_busy++;
            if (md_stall) n_stall++;
        end
        @(posedge clk);
        if (rst) begin
            m_rem = 0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && !m_pdz) begin
                m_hi = m_ph;
                m_lo = m_pl;
            end
        end else if (st) begin
            if (op < 4'd4) begin
                r     = ref_md(op, rs, rt);
                m_pdz = r[64];
                m_ph  = r[63:32];
                m_pl  = r[31:0];
                m_rem = (op >= 4'd2) ? DIV_LAT : MULT_LAT;
            end else if (op == 4'd4) begin
                m_hi = rs;
            end else if (op == 4'd5) begin
                m_lo = rs;
            end
        end
    endtask

    task automatic idle(input int n, input logic dmd);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, dmd, 1'b0);
    endtask

    task automatic spec_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        #2;
        chk(tag, obs, exp);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        st;
        logic [3:0]  op;
        E_start = 1'b0; E_mdop = 4'd0; E_rs = 32'd0; E_rt = 32'd0; D_is_md = 1'b0; reset = 1'b1;
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        armed = 1'b1;
        idle(1, 1'b0);

        // MULT signed
        n_busy = 0;
        cyc(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MULT_LAT + 1, 1'b0);
        chk("t1_busy_len", n_busy, 32'd5);
        spec_chk("t1_hi", hi, 32'hFFFF_FFFF);
        spec_chk("t1_lo", lo, 32'hFFFF_FFFE);

        // MULTU
        cyc(1'b1, 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        idle(MULT_LAT + 1, 1'b0);
        spec_chk("t2_hi", hi, 32'h0000_0001);
        spec_chk("t2_lo", lo, 32'hFFFF_FFFE);

        // DIV signed, then DIVU by zero leaves HI/LO alone
        n_busy = 0;
        cyc(1'b1, 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DIV_LAT + 1, 1'b0);
        chk("t3_busy_len", n_busy, 32'd10);
        spec_chk("t3_hi", hi, 32'hFFFF_FFFF);
        spec_chk("t3_lo", lo, 32'hFFFF_FFFD);
        n_busy = 0;
        cyc(1'b1, 4'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        idle(DIV_LAT + 1, 1'b0);
        chk("t3z_busy_len", n_busy, 32'd10);
        spec_chk("t3z_hi", hi, 32'hFFFF_FFFF);
        spec_chk("t3z_lo", lo, 32'hFFFF_FFFD);

        // MULT in E with MFLO waiting in D
        n_stall = 0;
        cyc(1'b1, 4'd0, 32'd3, 32'd5, 1'b1, 1'b0);
        idle(MULT_LAT, 1'b1);
        chk("t4_stall_len", n_stall, 32'd6);
        cyc(1'b1, 4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("t4_stall_after", n_stall, 32'd6);
        chk("t4_mflo", last_mf, 32'd15);

        // MTHI then MFHI
        n_busy = 0;
        cyc(1'b1, 4'd4, 32'h0000_1234, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
        chk("t5_mfhi", last_mf, 32'h0000_1234);
        chk("t5_busy", n_busy, 32'd0);
        spec_chk("t5_hi", hi, 32'h0000_1234);

        // Reset during DIV busy cycle 3
        n_busy = 0;
        cyc(1'b1, 4'd2, 32'd100, 32'd7, 1'b0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("t6_busy_before", n_busy, 32'd3);
        idle(DIV_LAT + 2, 1'b0);
        chk("t6_busy_after", n_busy, 32'd3);
        spec_chk("t6_hi", hi, 32'd0);
        spec_chk("t6_lo", lo, 32'd0);

        // Random traffic; starts only when the model says the unit is idle
        for (int k = 0; k < 600; k++) begin
            st = (m_rem == 0) && ($urandom_range(0, 1) == 1);
            op = 4'($urandom_range(0, 7));
            cyc(st, op, pick_val(), pick_val(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
